cic_interpolator: RTL and testbench



---
 rtl/cic_interpolator.sv | 146 ++++++++++++++
 tb/tb_cic_interpolator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// Interpolating CIC: N comb stages at the sample rate, zero-stuffing upsample by RATE,
// then N pipelined integrator stages at the clock rate. All arithmetic wraps at OUT_WIDTH.
//
// state | meaning
// IDLE  | no sample in flight, ready for the next input
// RUN   | issuing RATE stage-0 samples (comb output at ph=0, zeros after)
module cic_interpolator #(
    parameter  int IN_WIDTH   = 8,
    parameter  int N_STAGES   = 2,
    parameter  int RATE       = 4,
    parameter  int DIFF_DELAY = 1,
    localparam int OUT_WIDTH  = IN_WIDTH + N_STAGES * $clog2(RATE * DIFF_DELAY)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid
);

    localparam int PH_W = $clog2(RATE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_nxt;
    logic [PH_W-1:0]        ph, ph_nxt;
    logic                   last_ph;
    logic                   accept;

    logic signed [OUT_WIDTH-1:0] dly    [N_STAGES][DIFF_DELAY];
    logic signed [OUT_WIDTH-1:0] comb_tap [N_STAGES];
    logic signed [OUT_WIDTH-1:0] comb_out;
    logic signed [OUT_WIDTH-1:0] comb_q;

    logic signed [OUT_WIDTH-1:0] s0;
    logic                        v0;
    logic signed [OUT_WIDTH-1:0] acc    [N_STAGES];
    logic                        vld    [N_STAGES];
    logic signed [OUT_WIDTH-1:0] int_in [N_STAGES];
    logic                        int_v  [N_STAGES];

    assign last_ph  = (ph == PH_W'(RATE - 1));
    assign in_ready = (state == IDLE) || last_ph;
    assign accept   = in_valid && in_ready;

    // Comb chain is combinational; each tap is the stage input stored in its delay line.
    always_comb begin
        logic signed [OUT_WIDTH-1:0] x;
        x = {{(OUT_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        for (int s = 0; s < N_STAGES; s++) begin
            comb_tap[s] = x;
            x = x - dly[s][DIFF_DELAY-1];
        end
        comb_out = x;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < N_STAGES; s++)
                for (int d = 0; d < DIFF_DELAY; d++)
                    dly[s][d] <= '0;
            comb_q <= '0;
        end else if (accept) begin
            for (int s = 0; s < N_STAGES; s++) begin
                dly[s][0] <= comb_tap[s];
                for (int d = 1; d < DIFF_DELAY; d++)
                    dly[s][d] <= dly[s][d-1];
            end
            comb_q <= comb_out;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ph    <= '0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
        end
    end

    // A sample arriving at the last phase continues the burst without a gap.
    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    ph_nxt    = '0;
                end
            end
            RUN: begin
                if (!last_ph) begin
                    ph_nxt = ph + 1'b1;
                end else if (accept) begin
                    ph_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                    ph_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ph_nxt    = '0;
            end
        endcase
    end

    always_comb begin
        v0 = (state == RUN);
        s0 = (state == RUN && ph == '0) ? comb_q : '0;
    end

    always_comb begin
        int_in[0] = s0;
        int_v[0]  = v0;
        for (int i = 1; i < N_STAGES; i++) begin
            int_in[i] = acc[i-1];
            int_v[i]  = vld[i-1];
        end
    end

    // Integrators only advance on valid, so input gaps freeze filter time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_STAGES; i++) begin
                acc[i] <= '0;
                vld[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (int_v[i])
                    acc[i] <= acc[i] + int_in[i];
                vld[i] <= int_v[i];
            end
        end
    end

    assign out_data  = acc[N_STAGES-1];
    assign out_valid = vld[N_STAGES-1];

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: behavioural CIC model feeds a timed scoreboard,
// plus fixed-sequence checks for impulse, constant, gapped and reset cases.
module tb_cic_interpolator;

    localparam int IW = 8;
    localparam int NS = 2;
    localparam int R  = 4;
    localparam int M  = 1;
    localparam int OW = IW + NS * $clog2(R * M);

    logic                 clk = 1'b0;
    logic                 rstn;
    logic signed [IW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;

    always #5 clk = ~clk;

    cic_interpolator #(
        .IN_WIDTH(IW), .N_STAGES(NS), .RATE(R), .DIFF_DELAY(M)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ready_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [OW-1:0] val;
        int                   due;
    } exp_t;

    exp_t                 sb  [$];
    logic signed [OW-1:0] cap [$];

    logic signed [OW-1:0] m_dly [NS][M];
    logic signed [OW-1:0] m_acc [NS];
    bit                   m_run;
    int                   m_ph;

    logic signed [OW-1:0] imp_tab [8];

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int d = 0; d < M; d++) m_dly[s][d] = '0;
            m_acc[s] = '0;
        end
        m_run = 1'b0;
        m_ph  = 0;
        sb.delete();
        cap.delete();
    endtask

    // Sample accepted at edge k: its R outputs are due at edges k+NS .. k+NS+R-1.
    task automatic model_accept(input logic signed [IW-1:0] d, input int k);
        logic signed [OW-1:0] x, y, s;
        x = d;
        for (int st = 0; st < NS; st++) begin
            y = x - m_dly[st][M-1];
            for (int j = M - 1; j > 0; j--) m_dly[st][j] = m_dly[st][j-1];
            m_dly[st][0] = x;
            x = y;
        end
        for (int j = 0; j < R; j++) begin
            s = (j == 0) ? x : '0;
            m_acc[0] = m_acc[0] + s;
            for (int i = 1; i < NS; i++) m_acc[i] = m_acc[i] + m_acc[i-1];
            sb.push_back('{val: m_acc[NS-1], due: k + NS + j});
        end
    endtask

    // One clock: check outputs of the previous edge, then drive the next inputs.
    task automatic tick(input bit v, input logic signed [IW-1:0] d);
        exp_t e;
        bit   acc_now;
        @(negedge clk);
        if (out_valid) begin
            cap.push_back(out_data);
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.val);
                check("out_time", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("missing_valid", out_valid, 1);
            e = sb.pop_front();
        end
        check("in_ready", in_ready, (!m_run || m_ph == R - 1));
        if (in_ready) ready_cnt++;
        in_valid = v;
        in_data  = d;
        acc_now  = v && in_ready;
        if (acc_now) begin
            model_accept(d, cyc + 1);
            m_run = 1'b1;
            m_ph  = 0;
        end else if (m_run) begin
            if (m_ph == R - 1) m_run = 1'b0;
            else m_ph++;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            tick(1'b0, '0);
            n++;
        end
        tick(1'b0, '0);
        tick(1'b0, '0);
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_impulse(input string tag);
        check({tag, "_count"}, cap.size() >= 8, 1);
        for (int i = 0; i < 8 && i < cap.size(); i++)
            check(tag, cap[i], imp_tab[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        imp_tab = '{1, 2, 3, 4, 3, 2, 1, 0};
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset, then idle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, '0);
            #1;
            check("idle_out_data", out_data, 0);
            check("idle_out_valid", out_valid, 0);
        end

        // Impulse, continuous input
        do_reset();
        tick(1'b1, 8'sd1);
        for (int i = 0; i < 40; i++) tick(1'b1, '0);
        drain();
        check_impulse("impulse");

        // Constant +1: ramp to DC gain of 4, in_ready every 4th cycle
        do_reset();
        ready_cnt = 0;
        for (int i = 0; i < 24; i++) tick(1'b1, 8'sd1);
        check("const1_ready_cnt", ready_cnt, 6);
        drain();
        check("const1_count", cap.size() >= 8, 1);
        if (cap.size() >= 8) begin
            check("const1_ramp0", cap[0], 1);
            check("const1_ramp1", cap[1], 2);
            check("const1_ramp2", cap[2], 3);
            check("const1_hold", cap[3], 4);
            check("const1_last", cap[cap.size()-1], 4);
        end

        // Constant full-scale negative: no wrap at the output
        do_reset();
        for (int i = 0; i < 40; i++) tick(1'b1, -8'sd128);
        drain();
        check("neg_count", cap.size() >= 8, 1);
        if (cap.size() >= 8) begin
            check("neg_steady", cap[cap.size()-1], -512);
            check("neg_steady2", cap[cap.size()-5], -512);
        end

        // Gapped impulse matches the gapless sequence
        do_reset();
        tick(1'b1, 8'sd1);
        for (int i = 0; i < 10; i++) tick(1'b0, '0);
        for (int i = 0; i < 40; i++) tick(1'b1, '0);
        drain();
        check_impulse("gapped");

        // Reset mid-burst at ph=2, then impulse again
        do_reset();
        tick(1'b1, 8'sd1);
        tick(1'b1, '0);
        tick(1'b1, '0);
        do_reset();
        tick(1'b0, '0);
        #1;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_data", out_data, 0);
        tick(1'b1, 8'sd1);
        for (int i = 0; i < 40; i++) tick(1'b1, '0);
        drain();
        check_impulse("after_reset");

        // Random samples with random gaps against the model
        do_reset();
        for (int i = 0; i < 200; i++)
            tick(($urandom_range(0, 3) != 0), IW'($urandom));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
